// File: rtl/fp_accumulator.sv
// Single-precision streaming accumulator: sums a packet of IEEE-754 operands one at a time
// through a fixed align/add/normalise/round sequence and presents the total with its element count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for an element; in_ready high
// S_ALIGN | pick larger magnitude as A, shift B right with sticky
// S_ADD   | add or subtract significands
// S_NORM  | renormalise to hidden bit, adjust exponent
// S_ROUND | round to nearest even, update accumulator and count
// S_DONE  | hold completed sum until out_ready
module fp_accumulator #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_sum,
   output logic [COUNT_W-1:0] out_count,
   output logic               busy
);
   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
   state_t r_state, w_next_state;

   logic [31:0]        r_acc, r_op, r_bypass_val;
   logic               r_last, r_bypass;
   logic [COUNT_W-1:0] r_count;
   logic               r_sign_a, r_sign_b, r_sign, r_zero;
   logic [7:0]         r_exp_a;
   logic [26:0]        r_sig_a, r_sig_b, r_sig;
   logic [27:0]        r_sum;
   logic signed [9:0]  r_exp;

   logic               w_op_big, w_lost, w_bypass, w_round_up;
   logic [31:0]        w_a, w_b, w_bypass_val, w_result;
   logic [7:0]         w_diff;
   logic [26:0]        w_sig_b_full, w_sig_b_shift;
   logic [4:0]         w_lzc;
   logic [24:0]        w_m;
   logic signed [9:0]  w_exp_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next_state = S_ALIGN;
         S_ALIGN: w_next_state = S_ADD;
         S_ADD:   w_next_state = S_NORM;
         S_NORM:  w_next_state = S_ROUND;
         S_ROUND: w_next_state = r_last ? S_DONE : S_IDLE;
         S_DONE:  if (out_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign out_sum   = r_acc;
   assign out_count = r_count;

   // Alignment; zero, infinity and NaN operands skip the arithmetic and resolve directly.
   always_comb begin
      w_op_big      = (r_op[30:0] >= r_acc[30:0]);
      w_a           = w_op_big ? r_op : r_acc;
      w_b           = w_op_big ? r_acc : r_op;
      w_diff        = w_a[30:23] - w_b[30:23];
      w_sig_b_full  = {1'b1, w_b[22:0], 3'b000};
      w_lost        = 1'b0;
      w_sig_b_shift = 27'd1;
      if (w_diff < 8'd27) begin
         w_sig_b_shift = w_sig_b_full >> w_diff[4:0];
         w_lost        = |(w_sig_b_full & ~({27{1'b1}} << w_diff[4:0]));
      end
      w_bypass     = 1'b1;
      w_bypass_val = r_acc;
      if (r_op[30:23] == 8'hFF)       w_bypass_val = (r_acc[30:23] == 8'hFF) ? r_acc : r_op;
      else if (r_acc[30:23] == 8'hFF) w_bypass_val = r_acc;
      else if (r_op[30:23] == 8'h00)  w_bypass_val = r_acc;
      else if (r_acc[30:23] == 8'h00) w_bypass_val = r_op;
      else                            w_bypass     = 1'b0;
   end

   always_comb begin
      w_lzc = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (r_sum[i]) w_lzc = 5'(26 - i);
      end
   end

   always_comb begin
      w_round_up = r_sig[2] & (r_sig[1] | r_sig[0] | r_sig[3]);
      w_m        = {1'b0, r_sig[26:3]} + {24'd0, w_round_up};
      w_exp_r    = w_m[24] ? r_exp + 10'sd1 : r_exp;
      if (r_bypass)                      w_result = r_bypass_val;
      else if (r_zero || r_exp <= 10'sd0) w_result = 32'd0;
      else if (w_exp_r >= 10'sd255)      w_result = {r_sign, 8'hFF, 23'd0};
      else                               w_result = {r_sign, w_exp_r[7:0], w_m[24] ? w_m[23:1] : w_m[22:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0; r_op <= '0; r_last <= 1'b0; r_count <= '0;
         r_bypass <= 1'b0; r_bypass_val <= '0;
         r_sign_a <= 1'b0; r_sign_b <= 1'b0; r_exp_a <= '0;
         r_sig_a <= '0; r_sig_b <= '0; r_sum <= '0;
         r_sign <= 1'b0; r_exp <= '0; r_sig <= '0; r_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_op   <= in_data;
               r_last <= in_last;
            end
            S_ALIGN: begin
               r_bypass     <= w_bypass;
               r_bypass_val <= w_bypass_val;
               r_sign_a     <= w_a[31];
               r_sign_b     <= w_b[31];
               r_exp_a      <= w_a[30:23];
               r_sig_a      <= {1'b1, w_a[22:0], 3'b000};
               r_sig_b      <= w_sig_b_shift | {26'd0, w_lost};
            end
            S_ADD: begin
               r_sum  <= (r_sign_a == r_sign_b) ? {1'b0, r_sig_a} + {1'b0, r_sig_b}
                                                : {1'b0, r_sig_a} - {1'b0, r_sig_b};
               r_sign <= r_sign_a;
               r_exp  <= $signed({2'b00, r_exp_a});
            end
            S_NORM: begin
               r_zero <= (r_sum == 28'd0);
               if (r_sum[27]) begin
                  r_sig <= {r_sum[27:2], r_sum[1] | r_sum[0]};
                  r_exp <= r_exp + 10'sd1;
               end else begin
                  r_sig <= r_sum[26:0] << w_lzc;
                  r_exp <= r_exp - $signed({5'd0, w_lzc});
               end
            end
            S_ROUND: begin
               r_acc <= w_result;
               if (r_count != {COUNT_W{1'b1}}) r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
            S_DONE: if (out_ready) begin
               r_acc   <= '0;
               r_count <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator: directed operand streams with hand-computed sums,
// a monitor that pops expected {sum,count} on every output handshake.
module tb_fp_accumulator;
   localparam int COUNT_W = 16;

   logic               clk = 1'b0;
   logic               rst_n, in_valid, in_ready, in_last, out_valid, out_ready, busy;
   logic [31:0]        in_data, out_sum;
   logic [COUNT_W-1:0] out_count;

   int          checks = 0;
   int          errors = 0;
   logic [47:0] exp_q[$];
   logic [47:0] mon_e;

   fp_accumulator #(.COUNT_W(COUNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_count(out_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: a handshake seen at the falling edge completes on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got sum %h count %0d expected no output", out_sum, out_count);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_sum", out_sum, mon_e[47:16]);
            check("out_count", {16'd0, out_count}, {16'd0, mon_e[15:0]});
         end
      end
   end

   task automatic expect_sum(input logic [31:0] s, input int c);
      exp_q.push_back({s, 16'(c)});
   endtask

   // Returns one time unit after the accepting rising edge.
   task automatic send(input logic [31:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_last = l;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 for 50 cycles expected 1");
      end
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(n < 100), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int bad;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out_count", {16'd0, out_count}, 32'd0);
      check("rst_out_sum", out_sum, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

      // 1+2+3 = 6; also measure in_ready return and out_valid latency (4 edges after the accept edge)
      send(32'h3F800000, 1'b0);
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      check("in_ready_latency", n, 32'd4);
      send(32'h40000000, 1'b0);
      expect_sum(32'h40C00000, 3);
      send(32'h40400000, 1'b1);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("out_valid_latency", n, 32'd4);
      wait_drain();

      expect_sum(32'h00000000, 2); send(32'h3FC00000, 1'b0); send(32'hBFC00000, 1'b1);
      expect_sum(32'h3F800000, 2); send(32'h3F800000, 1'b0); send(32'h33800000, 1'b1);
      expect_sum(32'h3F800001, 2); send(32'h3F800000, 1'b0); send(32'h34000000, 1'b1);
      expect_sum(32'h3F800001, 2); send(32'h3F800000, 1'b0); send(32'h33C00000, 1'b1);
      expect_sum(32'h3F000000, 2); send(32'h3F800000, 1'b0); send(32'hBF000000, 1'b1);
      expect_sum(32'hBF800000, 2); send(32'h3F800000, 1'b0); send(32'hC0000000, 1'b1);
      expect_sum(32'h7F800000, 2); send(32'h7F7FFFFF, 1'b0); send(32'h7F7FFFFF, 1'b1);
      expect_sum(32'h7F800000, 2); send(32'h7F800000, 1'b0); send(32'h3F800000, 1'b1);
      expect_sum(32'h40000000, 2); send(32'h00000001, 1'b0); send(32'h40000000, 1'b1);
      wait_drain();

      // Backpressure: hold the result for 10 cycles
      out_ready = 1'b0;
      expect_sum(32'h40000000, 2);
      send(32'h3F800000, 1'b0);
      send(32'h3F800000, 1'b1);
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("bp_reach_done", 32'(n < 20), 32'd1);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_sum !== 32'h40000000 || out_count !== 16'd2 || in_ready !== 1'b0)
            bad++;
      end
      check("bp_hold_stable_cycles_bad", bad, 32'd0);
      check("bp_sum_held", out_sum, 32'h40000000);
      @(posedge clk);
      #1 out_ready = 1'b1;
      expect_sum(32'h40000000, 1);
      send(32'h40000000, 1'b1);
      wait_drain();

      // Reset during the ADD cycle abandons the partial sum
      send(32'h3F800000, 1'b0);
      send(32'h40000000, 1'b1);
      @(posedge clk);
      #1 check("busy_in_add", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_out_count", {16'd0, out_count}, 32'd0);
      check("midrst_out_sum", out_sum, 32'd0);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad++;
      end
      check("midrst_no_output_cycles_bad", bad, 32'd0);
      expect_sum(32'h40000000, 1);
      send(32'h40000000, 1'b1);
      wait_drain();

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
